ms_boot_seq: RTL and testbench

Parametrised boot/test command sequencer for the CPU subsystem. It walks a compile-time step table and issues one single-cycle DBIO write per step, for example "load FW from flash", "reset CPU" or "start CPU". Before each write it waits on a selectable readiness condition, bounded by a timeout, and skips steps whose mode mask does not match the sampled boot mode. It sits between the RSU/loader status signals and the DBIO master port. It reports ready or error to the top level.

---
 rtl/ms_boot_seq.sv | 153 +++++++++++++++
 tb/tb_ms_boot_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ms_boot_seq.sv
// rtl/ms_boot_seq.sv - table-driven boot/test command sequencer issuing DBIO writes
module ms_boot_seq #(
    parameter int CStepCnt    = 4,
    parameter int CDataLen    = 64,
    parameter int CCondCnt    = 2,
    parameter int CModeLen    = 2,
    parameter int CTimeoutLen = 16,
    parameter logic [CStepCnt*(20+CDataLen+CModeLen)-1:0] CStepTable = '0
) (
    input  logic                AClkH,
    input  logic                AResetH,
    input  logic                AClkHEn,
    input  logic                AStart,
    input  logic [CModeLen-1:0] AMode,
    input  logic [CCondCnt-1:0] ACond,
    input  logic                ADbioReady,
    output logic [11:0]         ADbioAddr,
    output logic [CDataLen-1:0] ADbioMosi,
    output logic [3:0]          ADbioMosiIdx,
    output logic [3:0]          ADbioMisoIdx,
    output logic                ADbioMosi1st,
    output logic                ADbioMiso1st,
    output logic                ABusy,
    output logic                AReady,
    output logic                AError,
    output logic [3:0]          AErrStep,
    output logic [7:0]          ATest
);
    localparam int EW = 20 + CDataLen + CModeLen;

    // All-zero is the reset encoding and behaves exactly like StStart.
    typedef enum logic [5:0] {
        ST_RESET = 6'b000000,
        ST_START = 6'b000001,
        ST_FETCH = 6'b000010,
        ST_WAIT  = 6'b000100,
        ST_ISSUE = 6'b001000,
        ST_READY = 6'b010000,
        ST_ERROR = 6'b100000
    } state_e;

    state_e                 state_q, state_d;
    // One extra bit so a full 16-entry table still reaches the end compare.
    logic [4:0]             step_q, step_d;
    logic [CModeLen-1:0]    mode_q, mode_d;
    logic [CTimeoutLen-1:0] timer_q, timer_d;
    logic [3:0]             err_step_q, err_step_d;

    logic [EW-1:0]          entry;
    logic [11:0]            ent_addr;
    logic [CDataLen-1:0]    ent_data;
    logic [3:0]             ent_idx;
    logic [CModeLen-1:0]    ent_mask;
    logic [2:0]             ent_sel;
    logic                   ent_pol;
    logic                   cond_met;

    always_comb begin
        entry = '0;
        for (int i = 0; i < CStepCnt; i++) begin
            if (step_q == 5'(i)) entry = CStepTable[i*EW +: EW];
        end
    end

    assign ent_pol  = entry[0];
    assign ent_sel  = entry[3:1];
    assign ent_mask = entry[4 +: CModeLen];
    assign ent_idx  = entry[4+CModeLen +: 4];
    assign ent_data = entry[8+CModeLen +: CDataLen];
    assign ent_addr = entry[8+CModeLen+CDataLen +: 12];

    // Selectors beyond the populated inputs never match, forcing a timeout.
    always_comb begin
        cond_met = 1'b0;
        if (ent_sel == 3'd0) cond_met = 1'b1;
        for (int k = 1; k <= CCondCnt; k++) begin
            if (ent_sel == 3'(k)) cond_met = (ACond[k-1] == ent_pol);
        end
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state_q    <= ST_RESET;
            step_q     <= '0;
            mode_q     <= '0;
            timer_q    <= '0;
            err_step_q <= '0;
        end else if (AClkHEn) begin
            state_q    <= state_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
            timer_q    <= timer_d;
            err_step_q <= err_step_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        mode_d     = mode_q;
        timer_d    = timer_q;
        err_step_d = err_step_q;
        case (state_q)
            ST_RESET, ST_START: begin
                mode_d     = AMode;
                step_d     = '0;
                timer_d    = '0;
                err_step_d = '0;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                if (step_q == 5'(CStepCnt)) begin
                    state_d = ST_READY;
                end else if ((ent_mask != '0) && ((ent_mask & mode_q) == '0)) begin
                    step_d = step_q + 5'd1;
                end else begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cond_met && ADbioReady) begin
                    state_d = ST_ISSUE;
                end else if (&timer_q) begin
                    err_step_d = step_q[3:0];
                    state_d    = ST_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                step_d  = step_q + 5'd1;
                state_d = ST_FETCH;
            end
            ST_READY, ST_ERROR: begin
                if (AStart) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
    end

    assign ADbioAddr    = (state_q == ST_ISSUE) ? ent_addr : '0;
    assign ADbioMosi    = (state_q == ST_ISSUE) ? ent_data : '0;
    assign ADbioMosiIdx = (state_q == ST_ISSUE) ? ent_idx  : '0;
    assign ADbioMisoIdx = '0;
    assign ADbioMosi1st = 1'b0;
    assign ADbioMiso1st = 1'b0;
    assign ABusy        = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_ISSUE);
    assign AReady       = (state_q == ST_READY);
    assign AError       = (state_q == ST_ERROR);
    assign AErrStep     = err_step_q;
    assign ATest        = {AError, AReady, state_q};
endmodule

// File: tb/tb_ms_boot_seq.sv
// tb/tb_ms_boot_seq.sv - scoreboard bench for ms_boot_seq
module tb_ms_boot_seq;
    localparam int STEPS = 3;
    localparam int DL    = 64;
    localparam int TL    = 5;
    localparam int TMO   = 1 << TL;

    localparam logic [85:0] E0 = {12'h100, 64'd1, 4'd2, 2'b01, 3'd0, 1'b0};
    localparam logic [85:0] E1 = {12'h000, 64'd3, 4'd1, 2'b00, 3'd1, 1'b1};
    localparam logic [85:0] E2 = {12'h000, 64'd5, 4'd1, 2'b00, 3'd2, 1'b1};
    localparam logic [STEPS*86-1:0] TABLE = {E2, E1, E0};

    logic          AClkH = 1'b0;
    logic          AResetH = 1'b1;
    logic          AClkHEn = 1'b1;
    logic          AStart = 1'b0;
    logic [1:0]    AMode = 2'b01;
    logic [1:0]    ACond = 2'b11;
    logic          ADbioReady = 1'b1;
    logic [11:0]   ADbioAddr;
    logic [DL-1:0] ADbioMosi;
    logic [3:0]    ADbioMosiIdx, ADbioMisoIdx;
    logic          ADbioMosi1st, ADbioMiso1st;
    logic          ABusy, AReady, AError;
    logic [3:0]    AErrStep;
    logic [7:0]    ATest;

    ms_boot_seq #(
        .CStepCnt(STEPS), .CDataLen(DL), .CCondCnt(2), .CModeLen(2),
        .CTimeoutLen(TL), .CStepTable(TABLE)
    ) dut (
        .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn), .AStart(AStart),
        .AMode(AMode), .ACond(ACond), .ADbioReady(ADbioReady),
        .ADbioAddr(ADbioAddr), .ADbioMosi(ADbioMosi), .ADbioMosiIdx(ADbioMosiIdx),
        .ADbioMisoIdx(ADbioMisoIdx), .ADbioMosi1st(ADbioMosi1st), .ADbioMiso1st(ADbioMiso1st),
        .ABusy(ABusy), .AReady(AReady), .AError(AError), .AErrStep(AErrStep), .ATest(ATest)
    );

    always #5 AClkH = ~AClkH;

    // Enabled-edge counter since reset release: cycle n is the state after n enabled edges.
    int cyc = 0;
    always @(posedge AClkH) begin
        if (AResetH) cyc <= 0;
        else if (AClkHEn) cyc <= cyc + 1;
    end

    typedef struct {
        logic [11:0]   addr;
        logic [DL-1:0] data;
        logic [3:0]    idx;
        int            at;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_pop = -1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [85:0] e, input int at);
        exp_t x;
        x.addr = e[85:74];
        x.data = e[73:10];
        x.idx  = e[9:6];
        x.at   = at;
        sb_q.push_back(x);
    endtask

    task automatic monitor();
        exp_t x;
        check("spare_zero", {ADbioMisoIdx, ADbioMosi1st, ADbioMiso1st}, 0);
        if (ATest[3] && cyc != last_pop) begin
            last_pop = cyc;
            if (sb_q.size() == 0) begin
                check("unexpected_cmd", {ADbioAddr, ADbioMosi[15:0]}, 0);
            end else begin
                x = sb_q.pop_front();
                check("cmd_addr", ADbioAddr, x.addr);
                check("cmd_data", ADbioMosi, x.data);
                check("cmd_idx", ADbioMosiIdx, x.idx);
                if (x.at >= 0) check("cmd_cycle", cyc, x.at);
            end
        end else if (!ATest[3]) begin
            check("idle_bus", {ADbioAddr, ADbioMosi, ADbioMosiIdx}, 0);
        end
    endtask

    task automatic tick();
        @(posedge AClkH);
        #1;
        monitor();
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 300) begin
            tick();
            guard++;
        end
        if (cyc < n) check("wait_cycle_bound", cyc, n);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!AReady && guard < 200) begin
            tick();
            guard++;
        end
        check("ready_reached", AReady, 1);
        check("ready_busy", ABusy, 0);
        check("ready_err", AError, 0);
        check("ready_test", ATest, 8'h50);
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        AResetH = 1'b1;
        tick();
        check("rst_test", ATest, 0);
        check("rst_flags", {ABusy, AReady, AError, AErrStep}, 0);
        check("rst_bus", {ADbioAddr, ADbioMosi, ADbioMosiIdx}, 0);
        check("rst_sb_empty", sb_q.size(), 0);
        last_pop = -1;
        AResetH = 1'b0;
    endtask

    initial begin
        // mode 01: all three steps, 3 cycles each
        AMode = 2'b01; ACond = 2'b11; ADbioReady = 1'b1; AClkHEn = 1'b1;
        do_reset();
        push(E0, 3); push(E1, 6); push(E2, 9);
        wait_cyc(2);
        AStart = 1'b1;
        tick();
        AStart = 1'b0;
        check("start_ignored_busy", ABusy, 1);
        wait_ready();

        // mode 10: loader step skipped in one fetch cycle
        AMode = 2'b10;
        do_reset();
        push(E1, 4); push(E2, 7);
        wait_ready();

        // step 1 waits on ACond[0] high for 20+ cycles
        AMode = 2'b01; ACond = 2'b10;
        do_reset();
        push(E0, 3); push(E1, 26); push(E2, 29);
        wait_cyc(25);
        check("cond_wait_state", ATest, 8'h04);
        ACond = 2'b11;
        wait_ready();

        // step 1 times out, then AStart reruns from step 0
        ACond = 2'b10;
        do_reset();
        push(E0, 3);
        wait_cyc(5 + TMO - 1);
        check("tmo_before_err", AError, 0);
        check("tmo_before_test", ATest, 8'h04);
        tick();
        check("tmo_err", AError, 1);
        check("tmo_errstep", AErrStep, 1);
        check("tmo_test", ATest, 8'hA0);
        ACond = 2'b11;
        AStart = 1'b1;
        tick();
        AStart = 1'b0;
        check("restart_state", ATest, 8'h01);
        push(E0, -1); push(E1, -1); push(E2, -1);
        wait_ready();
        check("restart_errstep", AErrStep, 0);

        // reset while step 2 waits
        ACond = 2'b01;
        do_reset();
        push(E0, 3); push(E1, 6);
        wait_cyc(10);
        check("mid_wait_state", ATest, 8'h04);
        do_reset();
        ACond = 2'b11;
        push(E0, 3); push(E1, 6); push(E2, 9);
        wait_ready();

        // DBIO back-pressure, enable gaps on an issued command and during a timeout wait
        ACond = 2'b11; ADbioReady = 1'b0;
        do_reset();
        push(E0, 7); push(E1, 10);
        wait_cyc(6);
        check("bp_busy", ATest, 8'h04);
        ADbioReady = 1'b1;
        wait_cyc(10);
        AClkHEn = 1'b0;
        ACond = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_cmd", {ATest, ADbioMosi[7:0], ADbioMosiIdx}, {8'h08, 8'd3, 4'd1});
        end
        AClkHEn = 1'b1;
        wait_cyc(20);
        AClkHEn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        AClkHEn = 1'b1;
        wait_cyc(12 + TMO - 1);
        check("gap_before_err", AError, 0);
        tick();
        check("gap_err", AError, 1);
        check("gap_errstep", AErrStep, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
